// File: rtl/isr_defs.sv
// Shared definitions for the interrupt controller.
// State encoding, address width and default vector layout.
package isr_defs;

  localparam int ADDR_W = 12;

  localparam logic [ADDR_W-1:0] DEF_ISR_BASE   = 12'hF00;
  localparam logic [ADDR_W-1:0] DEF_VEC_STRIDE = 12'h010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    SERVICE  = 2'd2
  } isr_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Produces the winning index and a valid flag.
module irq_prio_enc #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  eligible,
  output logic [SW-1:0] sel,
  output logic          valid
);

  // scan high to low so the lowest index is written last
  always_comb begin
    sel   = '0;
    valid = |eligible;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) sel = SW'(i);
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Edge-latched interrupt controller driving the fetch redirect.
// One interrupt in flight at a time; RETI returns to idle.
module interrupt_ctrl
  import isr_defs::*;
#(
  parameter int                NUM_IRQ    = 4,
  parameter logic [ADDR_W-1:0] ISR_BASE   = DEF_ISR_BASE,
  parameter logic [ADDR_W-1:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_in,
  input  logic                gie_we,
  input  logic                gie_in,
  input  logic [ADDR_W-1:0]   PC,
  input  logic                PC_source,
  input  logic                stall_f,
  input  logic                reti_d,
  output logic [ADDR_W-1:0]   ISR_adr,
  output logic                branch_ISR,
  output logic                flush_isr,
  output logic [ADDR_W-1:0]   ret_adr,
  output logic                in_service,
  output logic [NUM_IRQ-1:0]  irq_ack,
  output logic [NUM_IRQ-1:0]  pending
);

  localparam int SW =
    (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  isr_state_t         state;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] mask;
  logic               gie;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] sel_oh;
  logic [NUM_IRQ-1:0] clr;
  logic [SW-1:0]      sel;
  logic               sel_vld;
  logic               go;

  assign rise     = irq_in & ~irq_prev;
  assign eligible = pending & mask & {NUM_IRQ{gie}};

  irq_prio_enc #(
    .N  (NUM_IRQ),
    .SW (SW)
  ) u_prio (
    .eligible (eligible),
    .sel      (sel),
    .valid    (sel_vld)
  );

  // fetch must be free to accept the redirect this cycle
  assign go = (state == IDLE) && sel_vld &&
              !stall_f && !PC_source;

  assign sel_oh = NUM_IRQ'(1) << sel;
  assign clr    = go ? sel_oh : '0;

  // edge capture; a new edge beats a same-cycle clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_prev <= '0;
      pending  <= '0;
    end else begin
      irq_prev <= irq_in;
      pending  <= rise | (pending & ~clr);
    end
  end

  // mask and global enable registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
      gie  <= 1'b0;
    end else begin
      if (mask_we) mask <= mask_in;
      if (gie_we)  gie  <= gie_in;
    end
  end

  // dispatch / service sequencing with registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ISR_adr    <= '0;
      branch_ISR <= 1'b0;
      flush_isr  <= 1'b0;
      irq_ack    <= '0;
      ret_adr    <= '0;
      in_service <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            state      <= DISPATCH;
            ISR_adr    <= ISR_BASE +
                          ADDR_W'(sel) * VEC_STRIDE;
            branch_ISR <= 1'b1;
            flush_isr  <= 1'b1;
            irq_ack    <= sel_oh;
          end
        end
        DISPATCH: begin
          state      <= SERVICE;
          ret_adr    <= PC;
          branch_ISR <= 1'b0;
          flush_isr  <= 1'b0;
          irq_ack    <= '0;
          in_service <= 1'b1;
        end
        SERVICE: begin
          if (reti_d) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Randomized scoreboard bench for interrupt_ctrl.
// Model predicts dispatches; a monitor checks DUT redirects.
module tb_interrupt_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  irq_in = '0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_in = '0;
  logic        gie_we = 1'b0;
  logic        gie_in = 1'b0;
  logic [11:0] PC = '0;
  logic        PC_source = 1'b0;
  logic        stall_f = 1'b0;
  logic        reti_d = 1'b0;
  logic [11:0] ISR_adr;
  logic        branch_ISR;
  logic        flush_isr;
  logic [11:0] ret_adr;
  logic        in_service;
  logic [3:0]  irq_ack;
  logic [3:0]  pending;

  interrupt_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .gie_we     (gie_we),
    .gie_in     (gie_in),
    .PC         (PC),
    .PC_source  (PC_source),
    .stall_f    (stall_f),
    .reti_d     (reti_d),
    .ISR_adr    (ISR_adr),
    .branch_ISR (branch_ISR),
    .flush_isr  (flush_isr),
    .ret_adr    (ret_adr),
    .in_service (in_service),
    .irq_ack    (irq_ack),
    .pending    (pending)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [11:0] adr;
    logic [3:0]  ack;
  } disp_t;

  int          checks = 0;
  int          errors = 0;
  int          n_disp = 0;
  int          rst_gen = 0;
  disp_t       q_disp[$];
  logic [11:0] q_ret[$];

  // reference model: pending set, enables, and a phase
  // 0 = free, 1 = redirect cycle, 2 = handler running
  logic [3:0]  m_pend = '0;
  logic [3:0]  m_prev = '0;
  logic [3:0]  m_mask = '0;
  logic        m_gie = 1'b0;
  int          m_st = 0;
  logic [3:0]  irq_cur = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_prev = '0;
    m_mask = '0;
    m_gie  = 1'b0;
    m_st   = 0;
    q_disp.delete();
    q_ret.delete();
  endtask

  // predict the effect of the coming rising edge
  task automatic model_step();
    logic [3:0] rs;
    logic [3:0] el;
    logic [3:0] cl;
    int         s;
    bit         go;
    rs = irq_in & ~m_prev;
    el = m_pend & m_mask & (m_gie ? 4'hF : 4'h0);
    go = (m_st == 0) && (el != 0) &&
         !stall_f && !PC_source;
    cl = '0;
    s  = -1;
    if (go) begin
      for (int i = 3; i >= 0; i--)
        if (el[i]) s = i;
      cl = 4'(1 << s);
      q_disp.push_back({12'(32'hF00 + s * 16), cl});
    end
    if (m_st == 1) begin
      q_ret.push_back(PC);
      m_st = 2;
    end else if (m_st == 2) begin
      if (reti_d) m_st = 0;
    end else if (go) begin
      m_st = 1;
    end
    m_pend = rs | (m_pend & ~cl);
    m_prev = irq_in;
    if (mask_we) m_mask = mask_in;
    if (gie_we)  m_gie  = gie_in;
  endtask

  task automatic cyc(input logic [3:0]  irq,
                     input bit          mwe,
                     input logic [3:0]  mv,
                     input bit          gwe,
                     input bit          gv,
                     input logic [11:0] pc,
                     input bit          pcs,
                     input bit          stl,
                     input bit          rt);
    @(negedge clock);
    chk("pending", 32'(pending), 32'(m_pend));
    chk("in_service", 32'(in_service),
        32'(m_st == 2));
    irq_in    = irq;
    mask_we   = mwe;
    mask_in   = mv;
    gie_we    = gwe;
    gie_in    = gv;
    PC        = pc;
    PC_source = pcs;
    stall_f   = stl;
    reti_d    = rt;
    model_step();
  endtask

  task automatic idle(input int n, input bit rt);
    for (int i = 0; i < n; i++)
      cyc(irq_cur, 0, 4'h0, 0, 0, 12'($urandom),
          0, 0, rt);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_branch"}, 32'(branch_ISR), 0);
    chk({tag, "_flush"}, 32'(flush_isr), 0);
    chk({tag, "_insvc"}, 32'(in_service), 0);
    chk({tag, "_ack"}, 32'(irq_ack), 0);
    chk({tag, "_pend"}, 32'(pending), 0);
    chk({tag, "_isradr"}, 32'(ISR_adr), 0);
    chk({tag, "_retadr"}, 32'(ret_adr), 0);
  endtask

  // drive a request into phase tgt, then reset right after
  // the edge that entered it
  task automatic reset_in(input int tgt);
    int n;
    n = 0;
    irq_cur = 4'b0000;
    cyc(4'b0001, 1, 4'hF, 1, 1, 12'h100, 0, 0, 0);
    while (m_st != tgt && n < 40) begin
      cyc(4'b0000, 0, 4'h0, 0, 0, 12'h104, 0, 0, 0);
      n++;
    end
    chk("reach_phase", 32'(m_st), 32'(tgt));
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    rst_gen++;
    #1;
    check_zero(tgt == 1 ? "rst_disp" : "rst_svc");
    model_reset();
    irq_in  = 4'b1000;
    irq_cur = 4'b1000;
    #1;
    reset_n = 1'b1;
    cyc(4'b1000, 1, 4'hF, 1, 1, 12'h200, 0, 0, 0);
    idle(6, 0);
    idle(1, 1);
    idle(4, 0);
    irq_cur = 4'b0000;
    idle(2, 0);
  endtask

  // monitor: every redirect must match the oldest prediction
  initial begin : monitor
    disp_t e;
    int    g;
    forever begin
      @(negedge clock);
      if (reset_n && branch_ISR) begin
        if (q_disp.size() == 0) begin
          chk("unexpected_branch", 1, 0);
        end else begin
          e = q_disp.pop_front();
          n_disp++;
          chk("isr_adr", 32'(ISR_adr), 32'(e.adr));
          chk("irq_ack", 32'(irq_ack), 32'(e.ack));
          chk("flush_isr", 32'(flush_isr), 1);
          g = rst_gen;
          @(negedge clock);
          if (g == rst_gen && reset_n) begin
            if (q_ret.size() == 0) begin
              chk("ret_missing", 1, 0);
            end else begin
              chk("ret_adr", 32'(ret_adr),
                  32'(q_ret.pop_front()));
            end
            chk("one_cycle_branch",
                32'(branch_ISR), 0);
            chk("svc_entered", 32'(in_service), 1);
          end
        end
      end else if (reset_n &&
                   (flush_isr || irq_ack != 0)) begin
        chk("stray_flush_ack",
            32'({flush_isr, irq_ack}), 0);
      end
    end
  end

  initial begin : stim
    bit          rt;
    bit          mwe;
    bit          gwe;
    logic [3:0]  mv;
    #1;
    check_zero("reset");
    @(posedge clock);
    #3;
    reset_n = 1'b1;

    // single source 2 with a known return PC
    cyc(4'b0000, 1, 4'hF, 1, 1, 12'h034, 0, 0, 0);
    cyc(4'b0100, 0, 4'h0, 0, 0, 12'h034, 0, 0, 0);
    cyc(4'b0000, 0, 4'h0, 0, 0, 12'h034, 0, 0, 0);
    cyc(4'b0000, 0, 4'h0, 0, 0, 12'h034, 0, 0, 0);
    idle(3, 0);
    idle(1, 1);
    idle(3, 0);

    // two simultaneous sources: 1 then 3
    cyc(4'b1010, 0, 4'h0, 0, 0, 12'h050, 0, 0, 0);
    idle(5, 0);
    idle(1, 1);
    idle(5, 0);
    idle(1, 1);
    idle(3, 0);

    // stall and taken branch defer the dispatch
    cyc(4'b0001, 0, 4'h0, 0, 0, 12'h060, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc(4'b0000, 0, 4'h0, 0, 0, 12'h060, 0, 1, 0);
    cyc(4'b0000, 0, 4'h0, 0, 0, 12'h064, 1, 0, 0);
    idle(4, 0);
    idle(1, 1);
    idle(2, 0);

    // masked request held, then released by mask write
    cyc(4'b0000, 1, 4'h0, 0, 0, 12'h070, 0, 0, 0);
    cyc(4'b0001, 0, 4'h0, 0, 0, 12'h070, 0, 0, 0);
    idle(4, 0);
    cyc(4'b0000, 1, 4'h1, 0, 0, 12'h074, 0, 0, 0);
    idle(4, 0);
    idle(1, 1);
    // same with the global enable
    cyc(4'b0000, 1, 4'hF, 1, 0, 12'h080, 0, 0, 0);
    cyc(4'b0001, 0, 4'h0, 0, 0, 12'h080, 0, 0, 0);
    idle(4, 0);
    cyc(4'b0000, 0, 4'h0, 1, 1, 12'h084, 0, 0, 0);
    idle(4, 0);
    idle(1, 1);
    idle(2, 0);

    // re-request of source 2 while it is in service
    cyc(4'b0100, 0, 4'h0, 0, 0, 12'h090, 0, 0, 0);
    cyc(4'b0000, 0, 4'h0, 0, 0, 12'h090, 0, 0, 0);
    idle(2, 0);
    cyc(4'b0100, 0, 4'h0, 0, 0, 12'h094, 0, 0, 0);
    idle(2, 0);
    idle(1, 1);
    idle(4, 0);
    idle(1, 1);
    idle(2, 0);
    // rise coincident with its own dispatch clear
    cyc(4'b0100, 0, 4'h0, 0, 0, 12'h0A0, 0, 1, 0);
    cyc(4'b0000, 0, 4'h0, 0, 0, 12'h0A0, 0, 1, 0);
    cyc(4'b0100, 0, 4'h0, 0, 0, 12'h0A4, 0, 0, 0);
    cyc(4'b0000, 0, 4'h0, 0, 0, 12'h0A4, 0, 0, 0);
    idle(3, 0);
    idle(1, 1);
    idle(4, 0);
    idle(1, 1);
    idle(3, 0);

    // asynchronous reset mid-dispatch and mid-service
    reset_in(1);
    reset_in(2);

    // randomized traffic
    cyc(4'b0000, 1, 4'hF, 1, 1, 12'h000, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      irq_cur = irq_cur ^ 4'($urandom & $urandom);
      rt  = (m_st == 2) ?
            ($urandom_range(0, 3) == 0) :
            ($urandom_range(0, 9) == 0);
      mwe = ($urandom_range(0, 19) == 0);
      mv  = ($urandom_range(0, 1) == 0) ?
            4'hF : 4'($urandom);
      gwe = ($urandom_range(0, 29) == 0);
      cyc(irq_cur, mwe, mv, gwe,
          $urandom_range(0, 4) != 0,
          12'($urandom),
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 4) == 0, rt);
    end

    // drain outstanding work
    irq_cur = 4'b0000;
    cyc(4'b0000, 1, 4'hF, 1, 1, 12'h000, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      idle(1, m_st == 2);
    idle(3, 0);

    chk("disp_queue_empty", 32'(q_disp.size()), 0);
    chk("ret_queue_empty", 32'(q_ret.size()), 0);
    chk("enough_dispatches", 32'(n_disp > 20), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
